// File: rtl/code_register.sv
// Password datapath: shifts keypad characters into an entry register, holds the stored code
// and reports a registered match. Optional master code enabled by CODE_REGISTER_MASTER_EN.
module code_register #(
    parameter int                        DIGITS       = 4,
    parameter int                        WIDTH        = 4,
    parameter logic [DIGITS*WIDTH-1:0]   DEFAULT_CODE = 16'h1234
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] digit_in,
    input  logic             pipo_shift,
    input  logic             pipo_reset,
    input  logic             pipo_load,
    output logic             pass_check,
    output logic             entry_full,
    output logic [2:0]       digit_count,
    output logic             load_err
);

    localparam int         ENTRY_W    = DIGITS * WIDTH;
    localparam logic [2:0] FULL_COUNT = 3'(DIGITS);
`ifdef CODE_REGISTER_MASTER_EN
    localparam logic [ENTRY_W-1:0] MASTER_CODE = ENTRY_W'(16'hA5A5);
`endif

    logic [ENTRY_W-1:0] r_entry;
    logic [ENTRY_W-1:0] r_stored;
    logic [2:0]         r_count;
    logic               r_pass_check;
    logic               r_entry_full;
    logic               r_load_err;

    logic [ENTRY_W-1:0] w_entry_next;
    logic [ENTRY_W-1:0] w_stored_next;
    logic [2:0]         w_count_next;
    logic               w_load_err;
    logic               w_match;

    // Reset beats load beats shift; a load samples the pre-shift entry.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_entry_next  = r_entry;
        w_stored_next = r_stored;
        w_count_next  = r_count;
        w_load_err    = 1'b0;
        if (pipo_reset) begin
            w_entry_next = '0;
            w_count_next = '0;
        end else begin
            if (pipo_load) begin
                if (r_count == FULL_COUNT) w_stored_next = r_entry;
                else                       w_load_err    = 1'b1;
            end
            if (pipo_shift) begin
                w_entry_next = (r_entry << WIDTH) | ENTRY_W'(digit_in);
                if (r_count != FULL_COUNT) w_count_next = r_count + 3'd1;
            end
        end
    end

    always_comb begin
        w_match = (w_count_next == FULL_COUNT) && (w_entry_next == w_stored_next);
`ifdef CODE_REGISTER_MASTER_EN
        if ((w_count_next == FULL_COUNT) && (w_entry_next == MASTER_CODE)) w_match = 1'b1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_entry      <= '0;
            r_count      <= '0;
            r_stored     <= DEFAULT_CODE;
            r_pass_check <= 1'b0;
            r_entry_full <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_entry      <= w_entry_next;
            r_count      <= w_count_next;
            r_stored     <= w_stored_next;
            r_pass_check <= w_match;
            r_entry_full <= (w_count_next == FULL_COUNT);
            r_load_err   <= w_load_err;
        end
    end

    assign pass_check  = r_pass_check;
    assign entry_full  = r_entry_full;
    assign digit_count = r_count;
    assign load_err    = r_load_err;

endmodule

// File: tb/tb_code_register.sv
// Self-checking bench for code_register: queue-based password model, per-cycle compare of two
// instances (default code 16'h1234 and 16'h0012), directed scenarios plus randomized pulses.
module tb_code_register;

`ifdef CODE_REGISTER_MASTER_EN
    localparam bit MASTER_EN = 1'b1;
`else
    localparam bit MASTER_EN = 1'b0;
`endif

    logic       clk;
    logic       clr;
    logic [3:0] digit_in;
    logic       pipo_shift;
    logic       pipo_reset;
    logic       pipo_load;
    logic       pass_a, full_a, lerr_a;
    logic [2:0] cnt_a;
    logic       pass_b, full_b, lerr_b;
    logic [2:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    code_register u_dut_a (
        .clk(clk), .clr(clr), .digit_in(digit_in), .pipo_shift(pipo_shift),
        .pipo_reset(pipo_reset), .pipo_load(pipo_load), .pass_check(pass_a),
        .entry_full(full_a), .digit_count(cnt_a), .load_err(lerr_a)
    );

    code_register #(.DEFAULT_CODE(16'h0012)) u_dut_b (
        .clk(clk), .clr(clr), .digit_in(digit_in), .pipo_shift(pipo_shift),
        .pipo_reset(pipo_reset), .pipo_load(pipo_load), .pass_check(pass_b),
        .entry_full(full_b), .digit_count(cnt_b), .load_err(lerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the characters held (oldest first), both stored codes, and the pending load error.
    logic [3:0]  mq[$];
    logic [15:0] m_stored_a;
    logic [15:0] m_stored_b;
    logic        m_lerr;

    function automatic logic [15:0] m_entry();
        logic [15:0] v = 16'h0;
        foreach (mq[i]) v = (v << 4) | 16'(mq[i]);
        return v;
    endfunction

    function automatic logic m_match(input logic [15:0] st);
        if (mq.size() != 4) return 1'b0;
        return (m_entry() == st) || (MASTER_EN && m_entry() == 16'hA5A5);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_stored_a = 16'h1234;
        m_stored_b = 16'h0012;
        m_lerr     = 1'b0;
    endtask

    task automatic model_update(input bit r, input bit l, input bit s, input logic [3:0] d);
        m_lerr = 1'b0;
        if (r) begin
            mq.delete();
        end else begin
            if (l) begin
                if (mq.size() == 4) begin
                    m_stored_a = m_entry();
                    m_stored_b = m_entry();
                end else begin
                    m_lerr = 1'b1;
                end
            end
            if (s) begin
                mq.push_back(d);
                if (mq.size() > 4) void'(mq.pop_front());
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a_pass",  16'(pass_a), 16'(m_match(m_stored_a)));
        check("a_full",  16'(full_a), 16'(mq.size() == 4));
        check("a_count", 16'(cnt_a),  16'(mq.size()));
        check("a_lerr",  16'(lerr_a), 16'(m_lerr));
        check("b_pass",  16'(pass_b), 16'(m_match(m_stored_b)));
        check("b_count", 16'(cnt_b),  16'(mq.size()));
        check("b_lerr",  16'(lerr_b), 16'(m_lerr));
    end

    task automatic step(input bit r, input bit l, input bit s, input logic [3:0] d);
        pipo_reset = r;
        pipo_load  = l;
        pipo_shift = s;
        digit_in   = d;
        @(posedge clk);
        model_update(r, l, s, d);
        #1;
    endtask

    task automatic enter4(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b0, 1'b1, code[i*4 +: 4]);
    endtask

    task automatic clear_entry();
        step(1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        clr = 1'b0;
        pipo_reset = 1'b0; pipo_load = 1'b0; pipo_shift = 1'b0; digit_in = 4'h0;
        model_reset();
        #1 clr = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pass",  16'(pass_a), 16'h0);
        check("rst_full",  16'(full_a), 16'h0);
        check("rst_count", 16'(cnt_a),  16'h0);
        check("rst_lerr",  16'(lerr_a), 16'h0);
        #1 clr = 1'b0;

        // Default code, digit_count steps 1..4
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'(i));
            check("dflt_count", 16'(cnt_a), 16'(i));
        end
        check("dflt_full", 16'(full_a), 16'h1);
        check("dflt_pass", 16'(pass_a), 16'h1);
        check("model_entry_1234", m_entry(), 16'h1234);

        clear_entry();
        check("clr_count", 16'(cnt_a), 16'h0);
        check("clr_pass",  16'(pass_a), 16'h0);

        enter4(16'h1235);
        check("wrong_pass", 16'(pass_a), 16'h0);

        // Partial entry 1,2 in a register whose code is 16'h0012
        clear_entry();
        step(1'b0, 1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b0, 1'b1, 4'h2);
        check("partial_b_pass",  16'(pass_b), 16'h0);
        check("partial_b_count", 16'(cnt_b),  16'h2);

        // Overflow with shift held for five cycles
        clear_entry();
        step(1'b0, 1'b0, 1'b1, 4'h9);
        enter4(16'h1234);
        check("ovf_count", 16'(cnt_a), 16'h4);
        check("ovf_pass",  16'(pass_a), 16'h1);
        check("model_ovf_entry", m_entry(), 16'h1234);

        // New code 7701
        clear_entry();
        enter4(16'h7701);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        check("load_pass", 16'(pass_a), 16'h1);
        check("load_lerr", 16'(lerr_a), 16'h0);
        clear_entry();
        enter4(16'h7701);
        check("new_code_pass", 16'(pass_a), 16'h1);
        clear_entry();
        enter4(16'h1234);
        check("old_code_pass", 16'(pass_a), 16'h0);

        // Rejected load
        clear_entry();
        step(1'b0, 1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        check("rej_lerr_hi", 16'(lerr_a), 16'h1);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        check("rej_lerr_lo", 16'(lerr_a), 16'h0);
        clear_entry();
        enter4(16'h7701);
        check("rej_stored_kept", 16'(pass_a), 16'h1);

        // Reset+load together: load dropped
        clear_entry();
        enter4(16'h1234);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        check("rl_lerr",  16'(lerr_a), 16'h0);
        check("rl_count", 16'(cnt_a),  16'h0);
        enter4(16'h7701);
        check("rl_stored_kept", 16'(pass_a), 16'h1);

        // Load+shift: stored takes the pre-shift entry 1234
        clear_entry();
        enter4(16'h1234);
        step(1'b0, 1'b1, 1'b1, 4'h9);
        check("ls_pass",  16'(pass_a), 16'h0);
        check("ls_count", 16'(cnt_a),  16'h4);
        clear_entry();
        enter4(16'h1234);
        check("ls_stored", 16'(pass_a), 16'h1);

        // Asynchronous clear mid-entry
        clear_entry();
        enter4(16'h1234);
        step(1'b0, 1'b0, 1'b1, 4'h1);
        clear_entry();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'h3);
        pipo_shift = 1'b0;
        #2 clr = 1'b1;
        #1;
        check("async_count", 16'(cnt_a),  16'h0);
        check("async_full",  16'(full_a), 16'h0);
        check("async_pass",  16'(pass_a), 16'h0);
        model_reset();
        @(negedge clk);
        #1 clr = 1'b0;

        // Master code
        enter4(16'hA5A5);
        check("master_pass", 16'(pass_a), 16'(MASTER_EN));

        // Randomized pulses
        for (int n = 0; n < 800; n++) begin
            logic [3:0] digs[8];
            logic [3:0] d;
            digs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h0, 4'hA, 4'h5};
            if ($urandom_range(0, 19) == 0) begin
                clear_entry();
                enter4(($urandom_range(0, 1) == 0) ? m_stored_a : 16'hA5A5);
            end else begin
                d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : digs[$urandom_range(0, 7)];
                step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
                     $urandom_range(0, 99) < 60, d);
            end
        end

        step(1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
